// File: rtl/microseq_pkg.sv
// Shared definitions for the microcode sequencer: microinstruction layout,
// ALU opcode and FSM state encodings, and the instruction decode helper.
package microseq_pkg;

    localparam int unsigned INSTR_W   = 19;
    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned IMM_W     = 8;

    // Microinstruction field positions
    localparam int unsigned OP_MSB      = 18;
    localparam int unsigned OP_LSB      = 16;
    localparam int unsigned DST_MSB     = 15;
    localparam int unsigned DST_LSB     = 14;
    localparam int unsigned SRCA_MSB    = 13;
    localparam int unsigned SRCA_LSB    = 12;
    localparam int unsigned SRCB_MSB    = 11;
    localparam int unsigned SRCB_LSB    = 10;
    localparam int unsigned IMM_SEL_BIT = 9;
    localparam int unsigned IMM_MSB     = 8;
    localparam int unsigned IMM_LSB     = 1;
    localparam int unsigned HALT_BIT    = 0;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOT = 3'b011,
        OP_ADD = 3'b100,
        OP_ADC = 3'b101,
        OP_MOV = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        op_e                  op;
        logic [REG_IDX_W-1:0] dst;
        logic [REG_IDX_W-1:0] src_a;
        logic [REG_IDX_W-1:0] src_b;
        logic                 imm_sel;
        logic [IMM_W-1:0]     imm;
        logic                 halt;
    } instr_t;

    // Split a raw ROM word into its named fields
    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.op      = op_e'(w[OP_MSB:OP_LSB]);
        d.dst     = w[DST_MSB:DST_LSB];
        d.src_a   = w[SRCA_MSB:SRCA_LSB];
        d.src_b   = w[SRCB_MSB:SRCB_LSB];
        d.imm_sel = w[IMM_SEL_BIT];
        d.imm     = w[IMM_MSB:IMM_LSB];
        d.halt    = w[HALT_BIT];
        return d;
    endfunction

endpackage

// File: rtl/microseq_alu.sv
// Combinational ALU for the microcode sequencer.
// Ports: op (operation), a/b (operands) -> y (result, adds wrap modulo 2^DATA_W).
module microseq_alu
    import microseq_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_ADD:  y = a + b;
            OP_ADC:  y = a + b + DATA_W'(1);
            OP_MOV:  y = b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches 19-bit microinstructions from an external ROM,
// executes them on a 4-entry register file, 3 cycles per instruction
// (FETCH, EXEC, WB), until a halt bit or the last ROM address.
// Ports: clock, reset (sync, active high), start (run from address 0),
//        busy (not idle), done (one-cycle end pulse), rom_addr (= PC),
//        rom_data (ROM word), dbg_sel/dbg_data (combinational register read),
//        result (last value produced for write-back).
// Build option: define ZERO_FLAG_EN to add output zero, set in WB to
//        (result == 0) on writing ops and held on NOP.
module microcode_sequencer
    import microseq_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0]   rom_data,
    input  logic [REG_IDX_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data,
    output logic [DATA_W-1:0]    result
`ifdef ZERO_FLAG_EN
    ,
    output logic                 zero
`endif
);

    localparam logic [ADDR_W-1:0] PC_LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_t            ir_q, ir_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef ZERO_FLAG_EN
    logic              zero_q, zero_d;
`endif

    logic [DATA_W-1:0] op_a, op_b, alu_y;

    // Operand selection from the latched instruction
    assign op_a = regs_q[ir_q.src_a];
    assign op_b = ir_q.imm_sel ? DATA_W'(ir_q.imm) : regs_q[ir_q.src_b];

    microseq_alu #(.DATA_W(DATA_W)) u_alu (
        .op (ir_q.op),
        .a  (op_a),
        .b  (op_b),
        .y  (alu_y)
    );

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            result_q <= '0;
            regs_q   <= '{default: '0};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
            regs_q   <= regs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        result_d = result_q;
        regs_d   = regs_q;
`ifdef ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = decode_instr(rom_data);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // NOP leaves result holding the last written-back value
                if (ir_q.op != OP_NOP) begin
                    result_d = alu_y;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                if (ir_q.op != OP_NOP) begin
                    regs_d[ir_q.dst] = result_q;
`ifdef ZERO_FLAG_EN
                    zero_d = (result_q == '0);
`endif
                end
                // Stop at the last address rather than wrapping the PC
                if (ir_q.halt || (pc_q == PC_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags registered alongside the state they describe
    assign busy_d = (state_d != ST_IDLE);
    assign done_d = (state_d == ST_DONE);

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_addr = pc_q;
    assign result   = result_q;
    assign dbg_data = regs_q[dbg_sel];
`ifdef ZERO_FLAG_EN
    assign zero     = zero_q;
`endif

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, microprogram address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, datapath and register width.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, level request to run the microprogram from address 0.
REQ-006 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-007 The block SHALL have port done, output, 1, one-cycle pulse when the program ends.
REQ-008 The block SHALL have port rom_addr, output, ADDR_W, equal to the current PC.
REQ-009 The block SHALL have port rom_data, input, 19, combinational microinstruction from an external ROM.
REQ-010 The block SHALL have port dbg_sel, input, 2, register-file read select.
REQ-011 The block SHALL have port dbg_data, output, DATA_W, combinational read of register dbg_sel.
REQ-012 The block SHALL have port result, output, DATA_W, last written-back value.

Function
REQ-013 The microinstruction word SHALL be decoded as [18:16] op, [15:14] dst, [13:12] srcA, [11:10] srcB, [9] imm_sel, [8:1] imm8, [0] halt.
REQ-014 Operand B SHALL be imm8 when imm_sel=1, else reg[srcB]; operand A SHALL always be reg[srcA].
REQ-015 Ops SHALL be: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 A+B (cin 0), 101 A+B+1, 110 MOV B, 111 NOP (no write).
REQ-016 Add results SHALL be truncated modulo 2^DATA_W; carry-out is discarded.
REQ-017 The FSM states SHALL be IDLE, FETCH, EXEC, WB, DONE.
REQ-018 In IDLE with start=1, the FSM SHALL set PC to 0 and go to FETCH; with start=0 it SHALL stay in IDLE.
REQ-019 FETCH SHALL latch rom_data into the instruction register and go to EXEC.
REQ-020 EXEC SHALL latch the ALU output into the result register and go to WB.
REQ-021 WB SHALL write the result to reg[dst] unless op=NOP.
REQ-022 WB SHALL go to DONE if halt=1 or PC=2^ADDR_W-1; otherwise it SHALL increment PC and go to FETCH.
REQ-023 The PC SHALL never wrap to 0 while running.
REQ-024 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-025 Each instruction SHALL take exactly 3 cycles; with start sampled at edge 0, done SHALL be high in cycle 3N+1 for an N-instruction program.
REQ-026 start asserted while busy SHALL be ignored.
REQ-027 start held high through DONE SHALL restart the program on the IDLE cycle after done.
REQ-028 rom_data SHALL be sampled only in FETCH; changes in any other state SHALL have no effect.

Reset
REQ-029 On reset, state SHALL go to IDLE, PC to 0, IR, result and all four registers to 0, and done and busy to 0.
REQ-030 Reset SHALL take priority over every transition, including mid-program and the DONE cycle; a reset in DONE suppresses the done pulse.

Configuration
REQ-031 With ZERO_FLAG_EN defined, an output port zero (1 bit) SHALL be present, updated in WB to (result==0) on writing ops, held on NOP, and reset to 0.
REQ-032 Without ZERO_FLAG_EN, port zero and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Package microseq_pkg SHALL hold the op enum, the state enum, the instruction field positions and the word width constant 19.
REQ-034 One combinational sub-module, microseq_alu (op, a, b -> y), SHALL implement REQ-015 and REQ-016; all sequencing SHALL live in microcode_sequencer.

Verification
REQ-035 The bench SHALL check: addr0 MOV r0,#0x0F; addr1 r1=r0+#0x01 with halt -> r1=0x10, result=0x10, done in cycle 7.
REQ-036 The bench SHALL check: r0=0xFF, then ADD r2=r0+#0x01 -> r2=0x00, and zero=1 when ZERO_FLAG_EN is defined.
REQ-037 The bench SHALL check: a program with no halt bits set -> 64 instructions execute, PC stops at 63, done in cycle 193.
REQ-038 The bench SHALL check: reset asserted during EXEC of instruction 2 -> next cycle IDLE, all registers 0, no done pulse.
REQ-039 The bench SHALL check: start re-asserted while busy -> PC is not reset and the done cycle is unchanged.
REQ-040 The bench SHALL check: r0=0xA5, then NOT r3=~r0 and XOR r1=r0^#0xFF -> r3=0x5A and r1=0x5A.
